piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in/serial-out stage that sits directly upstream of the team's N-bit SIPO shift register and drives its `serial_in`. It accepts N-bit words over a valid/ready handshake and buffers one word while another is shifting. It emits one bit per clock on `serial_out`, with `serial_valid` and `frame_start` qualifiers so the consumer can align word boundaries. An optional idle gap can be inserted between words.

## Interface
- `N`, default 4: word width; legal range is N ≥ 2.
- `MSB_FIRST`, default 1: 1 sends bit N-1 first; 0 sends bit 0 first.
- `GAP`, default 0: number of idle cycles forced between consecutive words; legal range is 0–15.

- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset; 0 clears all state immediately.
- `in_data` input, N bits: parallel word; sampled when `in_valid && in_ready`.
- `in_valid` input, 1 bit: upstream has a word.
- `in_ready` output, 1 bit: holding buffer empty; equals `!hold_full`.
- `serial_out` output, 1 bit: registered serial data; 0 whenever `serial_valid` = 0.
- `serial_valid` output, 1 bit: registered; 1 while a data bit is on `serial_out`.
- `frame_start` output, 1 bit: registered; 1 only during the first bit of each word.
- `busy` output, 1 bit: 1 when state ≠ IDLE or `hold_full` = 1.

## Operation
- Storage:
  - Holding register `hold_data[N-1:0]` with flag `hold_full`.
  - Shift register `sh[N-1:0]`.
  - Bit counter `cnt` of width $clog2(N).
  - Gap counter `gcnt`, 4 bits.
- Accept: on an edge with `in_valid && !hold_full`, `hold_data` ← `in_data` and `hold_full` ← 1.
  - Upstream must hold `in_data` stable while `in_valid` = 1 and `in_ready` = 0.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - If `hold_full`, the next edge loads the word, clears `hold_full`, sets `cnt` ← 0 and enters SHIFT.
  - On that same edge, outputs become `serial_out` = first bit, `serial_valid` = 1, `frame_start` = 1.
- SHIFT: each edge sets `cnt` ← `cnt`+1, presents the next bit, and drives `frame_start` = 0.
- End of word: the edge with `cnt` = N-1 ends the last bit.
  - If `GAP` = 0 and `hold_full`: load the next word directly and stay in SHIFT. `frame_start` = 1 and `serial_valid` stays 1.
  - Else if `GAP` > 0: enter GAP with `gcnt` ← `GAP`-1, `serial_valid` = 0, `serial_out` = 0.
  - Else: go to IDLE with `serial_valid` = 0.
- GAP:
  - Decrement `gcnt` each edge.
  - The edge with `gcnt` = 0 loads a held word into SHIFT if `hold_full`, otherwise goes to IDLE.
- Bit order: MSB_FIRST=1 sends `in_data[N-1]` down to `[0]`; MSB_FIRST=0 sends `[0]` up to `[N-1]`.
- An accept and a load never occur on the same edge: `in_ready` is low whenever `hold_full` is set.
  - Because N ≥ 2, the hold buffer always refills before the current word ends, provided upstream presents the next word promptly.

## Timing
- Reset values:
  - state = IDLE.
  - `hold_full`, `cnt`, `gcnt`, `sh` = 0.
  - `serial_out`, `serial_valid`, `frame_start`, `busy` = 0.
  - `in_ready` = 1.
- Latency: a word accepted at edge E has its first bit valid after edge E+1, with the last bit valid after edge E+N.
- Throughput:
  - `GAP` = 0 gives N bits per N cycles, with no bubbles while upstream keeps `hold_full` ahead.
  - `GAP` = G gives one word per N+G cycles.
- Reset mid-word: the current and held words are discarded, outputs drop to 0 asynchronously, and no partial frame resumes.
- `in_valid` while `hold_full` = 1 is ignored; the word stays pending at upstream.
- `in_ready` is a pure function of registered state, with no combinational path from `in_valid`.

## Structure
- Shared package `serdes_pkg` holds:
  - the state enum (IDLE, SHIFT, GAP);
  - `function automatic` bit select for MSB/LSB ordering;
  - the default width constant 4, shared with the SIPO.
- No sub-module; this is a single module with one FSM.

## Test plan
- N=4, MSB_FIRST=1: send `4'b1011` → `serial_out` 1,0,1,1 on four consecutive cycles starting the cycle after edge E+1. `serial_valid` is high for exactly 4 cycles; `frame_start` is high on the first only.
- Back-to-back: send `1011` then `0110` with `in_valid` held → 8 contiguous valid bits 1,0,1,1,0,1,1,0. `frame_start` pulses on bits 1 and 5; `in_ready` is low while the second word is held.
- MSB_FIRST=0: send `4'b1011` → serial sequence 1,1,0,1.
- GAP=2: send two words → 4 valid bits, 2 cycles with `serial_valid` = 0 and `serial_out` = 0, then 4 valid bits.
- Reset asserted low after bit 2 of a word, with a second word held → outputs 0 immediately and `in_ready` = 1. After release, nothing is emitted until a new accept.
- Loopback: `serial_out` drives the SIPO `serial_in`, with SIPO enabled by `serial_valid`. After each 4-bit frame, SIPO `parallel_out` equals the transmitted word for `1011`, `0110` and `1111`.

Source files
------------

// File: rtl/serdes_pkg.sv
// Definitions shared by the serializer/deserializer pair: FSM states,
// the common default word width and the bit-order helper.
package serdes_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } state_e;

   // Maps the position within a frame (0 = first bit on the wire) to the word bit index.
   function automatic int unsigned bit_index(int unsigned n, int unsigned pos, bit msb_first);
      return msb_first ? (n - 1 - pos) : pos;
   endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with a one-word holding buffer, a valid/ready
// input handshake and an optional idle gap between consecutive words.
module piso_serializer
   import serdes_pkg::*;
#(
   parameter int N         = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1,
   parameter int GAP       = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         serial_out,
   output logic         serial_valid,
   output logic         frame_start,
   output logic         busy
);

   localparam int CW = $clog2(N);

   state_e         state_q, state_d;
   logic [N-1:0]   hold_data_q, hold_data_d;
   logic           hold_full_q, hold_full_d;
   logic [N-1:0]   sh_q, sh_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [3:0]     gcnt_q, gcnt_d;
   logic           serial_out_q, serial_out_d;
   logic           serial_valid_q, serial_valid_d;
   logic           frame_start_q, frame_start_d;

   logic           load;
   logic [CW-1:0]  cnt_nxt;
   logic [CW-1:0]  idx_first;
   logic [CW-1:0]  idx_next;

   assign cnt_nxt   = cnt_q + 1'b1;
   assign idx_first = CW'(bit_index(N, 0, MSB_FIRST));
   assign idx_next  = CW'(bit_index(N, 32'(cnt_nxt), MSB_FIRST));

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d        = state_q;
      hold_data_d    = hold_data_q;
      hold_full_d    = hold_full_q;
      sh_d           = sh_q;
      cnt_d          = cnt_q;
      gcnt_d         = gcnt_q;
      serial_out_d   = 1'b0;
      serial_valid_d = 1'b0;
      frame_start_d  = 1'b0;
      load           = 1'b0;

      if (in_valid && !hold_full_q) begin
         hold_data_d = in_data;
         hold_full_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (hold_full_q) load = 1'b1;
         end
         ST_SHIFT: begin
            if (cnt_q == CW'(N - 1)) begin
               if (GAP == 0 && hold_full_q) begin
                  load = 1'b1;
               end else if (GAP > 0) begin
                  state_d = ST_GAP;
                  gcnt_d  = 4'(GAP - 1);
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d          = cnt_nxt;
               serial_valid_d = 1'b1;
               serial_out_d   = sh_q[idx_next];
            end
         end
         ST_GAP: begin
            if (gcnt_q == 4'd0) begin
               if (hold_full_q) load = 1'b1;
               else             state_d = ST_IDLE;
            end else begin
               gcnt_d = gcnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Load only happens with the buffer full, so it never collides with an accept.
      if (load) begin
         state_d        = ST_SHIFT;
         sh_d           = hold_data_q;
         hold_full_d    = 1'b0;
         cnt_d          = '0;
         serial_out_d   = hold_data_q[idx_first];
         serial_valid_d = 1'b1;
         frame_start_d  = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         hold_data_q    <= '0;
         hold_full_q    <= 1'b0;
         sh_q           <= '0;
         cnt_q          <= '0;
         gcnt_q         <= '0;
         serial_out_q   <= 1'b0;
         serial_valid_q <= 1'b0;
         frame_start_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         hold_data_q    <= hold_data_d;
         hold_full_q    <= hold_full_d;
         sh_q           <= sh_d;
         cnt_q          <= cnt_d;
         gcnt_q         <= gcnt_d;
         serial_out_q   <= serial_out_d;
         serial_valid_q <= serial_valid_d;
         frame_start_q  <= frame_start_d;
      end
   end

   assign in_ready     = !hold_full_q;
   assign busy         = (state_q != ST_IDLE) || hold_full_q;
   assign serial_out   = serial_out_q;
   assign serial_valid = serial_valid_q;
   assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three parameterisations side by side,
// per-cycle traces of {in_ready, serial_valid, serial_out, frame_start}.
module tb_piso_serializer;

   logic       clk;
   logic       rst_n;
   logic [3:0] din [3];
   logic [2:0] vld;
   wire  [2:0] rdy, so, sv, fs, bz;

   int n_checks = 0;
   int n_fail   = 0;
   int sel      = 0;

   logic [3:0] trace [$];
   logic [3:0] exp_q [$];
   logic [3:0] sipo;

   piso_serializer #(.N(4), .MSB_FIRST(1'b1), .GAP(0)) u_msb (
      .clk(clk), .reset(rst_n), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
      .serial_out(so[0]), .serial_valid(sv[0]), .frame_start(fs[0]), .busy(bz[0]));

   piso_serializer #(.N(4), .MSB_FIRST(1'b0), .GAP(0)) u_lsb (
      .clk(clk), .reset(rst_n), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
      .serial_out(so[1]), .serial_valid(sv[1]), .frame_start(fs[1]), .busy(bz[1]));

   piso_serializer #(.N(4), .MSB_FIRST(1'b1), .GAP(2)) u_gap (
      .clk(clk), .reset(rst_n), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
      .serial_out(so[2]), .serial_valid(sv[2]), .frame_start(fs[2]), .busy(bz[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) trace.push_back({rdy[sel], sv[sel], so[sel], fs[sel]});

   // Consumer SIPO on the MSB-first instance: shifts in one bit per valid cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)      sipo <= 4'b0000;
      else if (sv[0])  sipo <= {sipo[2:0], so[0]};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_trace(input string tag, input int n);
      for (int c = 0; c < 60 && trace.size() < n; c++) @(negedge clk);
      #1;
      check({tag, "_len"}, 32'(trace.size() >= n), 32'd1);
   endtask

   task automatic compare_trace(input string tag);
      wait_trace(tag, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s[%0d]", tag, i), 32'(trace[i]), 32'(exp_q[i]));
   endtask

   task automatic send1(input int k, input logic [3:0] w);
      @(negedge clk); #1;
      trace.delete();
      din[k] = w;
      vld[k] = 1'b1;
      @(negedge clk); #1;
      vld[k] = 1'b0;
   endtask

   task automatic send2(input int k, input logic [3:0] w1, input logic [3:0] w2);
      @(negedge clk); #1;
      trace.delete();
      din[k] = w1;
      vld[k] = 1'b1;
      @(negedge clk); #1;
      din[k] = w2;
      @(negedge clk);
      @(negedge clk); #1;
      vld[k] = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      vld   = 3'b000;
      for (int i = 0; i < 3; i++) din[i] = 4'h0;
      #12;
      check("rst_serial_out",   32'(so),  32'h0);
      check("rst_serial_valid", 32'(sv),  32'h0);
      check("rst_frame_start",  32'(fs),  32'h0);
      check("rst_busy",         32'(bz),  32'h0);
      check("rst_in_ready",     32'(rdy), 32'h7);
      @(negedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single word, MSB first: 1,0,1,1 with frame_start on the first bit only.
      sel = 0;
      send1(0, 4'b1011);
      exp_q = '{4'b0000, 4'b1111, 4'b1100, 4'b1110, 4'b1110, 4'b1000, 4'b1000, 4'b1000};
      compare_trace("msb_single");

      // Back-to-back: 8 contiguous bits, second frame_start on bit 5.
      send2(0, 4'b1011, 4'b0110);
      exp_q = '{4'b0000, 4'b1111, 4'b0100, 4'b0110, 4'b0110,
                4'b1101, 4'b1110, 4'b1110, 4'b1100, 4'b1000};
      compare_trace("b2b");

      // LSB first: 1011 goes out as 1,1,0,1.
      sel = 1;
      send1(1, 4'b1011);
      exp_q = '{4'b0000, 4'b1111, 4'b1110, 4'b1100, 4'b1110, 4'b1000};
      compare_trace("lsb_single");

      // GAP=2: two idle cycles with outputs low between the words.
      sel = 2;
      send2(2, 4'b1011, 4'b0110);
      exp_q = '{4'b0000, 4'b1111, 4'b0100, 4'b0110, 4'b0110, 4'b0000, 4'b0000,
                4'b1101, 4'b1110, 4'b1110, 4'b1100, 4'b1000};
      compare_trace("gap2");

      // Reset after bit 2 with the second word held.
      sel = 0;
      send2(0, 4'b1011, 4'b0110);
      check("pre_rst_held", 32'(rdy[0]), 32'h0);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_serial_out",   32'(so[0]), 32'h0);
      check("mid_rst_serial_valid", 32'(sv[0]), 32'h0);
      check("mid_rst_frame_start",  32'(fs[0]), 32'h0);
      check("mid_rst_in_ready",     32'(rdy[0]), 32'h1);
      check("mid_rst_busy",         32'(bz[0]), 32'h0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      trace.delete();
      repeat (6) @(negedge clk);
      #1;
      begin
         int valid_seen;
         valid_seen = 0;
         foreach (trace[i]) if (trace[i][2]) valid_seen++;
         check("no_resume_valid", 32'(valid_seen), 32'h0);
         check("no_resume_len", 32'(trace.size() >= 6), 32'h1);
      end
      check("post_rst_busy", 32'(bz[0]), 32'h0);

      // Loopback into the SIPO consumer.
      send1(0, 4'b1011);
      repeat (5) @(negedge clk);
      #1 check("loop_1011", 32'(sipo), 32'hB);
      send1(0, 4'b0110);
      repeat (5) @(negedge clk);
      #1 check("loop_0110", 32'(sipo), 32'h6);
      send1(0, 4'b1111);
      repeat (5) @(negedge clk);
      #1 check("loop_1111", 32'(sipo), 32'hF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
